psa_pipe: RTL and testbench
===========================

Name: psa_pipe

Overview:
- Parametrised, pipelined partitioned signed adder/subtractor for SIMD datapath ops (e.g. PADDSB/PSUBSB).
- Splits a W-bit word into LANES independent two's-complement lanes of LANE_W bits each.
- Adds or subtracts lane-wise, with per-transaction selectable saturation or wrap.
- Registers results behind a valid/ready handshake and keeps sticky overflow status plus an overflow event counter for the ALU/flag logic.

Parameters:
- LANE_W, 4, bits per lane (>=2).
- LANES, 4, number of lanes (>=1); W = LANE_W*LANES.
- CNT_W, 8, width of the overflow event counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  W  operand A, lane i = a[i*LANE_W +: LANE_W].
- b  input  W  operand B, same lane layout.
- sub  input  1  1 = lane-wise A-B, 0 = A+B; sampled with the beat.
- sat_en  input  1  1 = saturate overflowing lanes, 0 = wrap; sampled with the beat.
- out_valid  output  1  result beat available.
- out_ready  input  1  consumer accepts the result beat.
- sum  output  W  lane-wise result.
- ovfl  output  LANES  per-lane overflow flags for the current result beat.
- err  output  1  sticky: any lane overflowed since the last reset or clear.
- ovfl_cnt  output  CNT_W  count of delivered beats with any ovfl bit set.
- clr_err  input  1  synchronous clear of err and ovfl_cnt.

Behaviour:
- Reset (asynchronous, immediate): all pipeline valid bits = 0, out_valid = 0, sum = 0, ovfl = 0, err = 0, ovfl_cnt = 0. Any in-flight beats are discarded and never emitted.
- Pipeline, two stages, S1 then S2. Latency is 2 cycles from the in_valid&&in_ready edge to out_valid with no stall. Throughput is 1 beat per cycle.
- S1 registers, per lane: raw = A + (sub ? ~B : B) + sub, truncated to LANE_W bits, plus the overflow bit and the sat_en bit.
- Overflow rule, add: sign(A) == sign(B) and sign(raw) != sign(A).
- Overflow rule, sub: sign(A) != sign(B) and sign(raw) != sign(A).
- S2 registers sum and ovfl. For an overflowing lane with sat_en = 1:
  - raw sign 1 (positive overflow) gives +max = 0 followed by LANE_W-1 ones.
  - raw sign 0 (negative overflow) gives -min = 1 followed by LANE_W-1 zeros.
- For a non-overflowing lane, or when sat_en = 0, the lane output is raw. ovfl is reported in both modes.
- No carry ever propagates between lanes.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is combinational from out_ready; there is no combinational path from in_valid to in_ready.
- While out_valid = 1 and out_ready = 0: sum, ovfl and out_valid hold stable, and S1 holds if full.
- A beat transfers when valid and ready are both 1 on a rising edge. Beats are delivered in acceptance order with none dropped or duplicated.
- Sticky status is updated at the output handshake (out_valid && out_ready):
  - If |ovfl, then err <= 1 and ovfl_cnt increments, saturating at 2^CNT_W-1 with no wrap.
  - If clr_err = 1 and no overflowing handshake occurs that cycle, err <= 0 and ovfl_cnt <= 0.
  - If clr_err = 1 coincides with an overflowing handshake, the new event wins: err = 1, ovfl_cnt = 1.
- Boundaries:
  - Pipeline full (2 beats held) with out_ready = 0 gives in_ready = 0.
  - out_ready rising with both stages full lets S2 drain, S1 move to S2 and a new beat enter S1, all in the same cycle.
  - in_valid while in_ready = 0 is ignored. The source must hold the beat.

Test Plan (LANE_W=4, LANES=4, CNT_W=8 unless noted):
- a=16'h1234, b=16'h1111, sub=0, sat_en=1 -> 2 cycles later sum=16'h2345, ovfl=4'b0000, err=0, ovfl_cnt=0.
- a=16'h7777, b=16'h1111, add, sat_en=1 -> sum=16'h7777, ovfl=4'b1111, err=1, ovfl_cnt=1.
  - Then a=16'h8888, b=16'h8888 -> sum=16'h8888, ovfl=4'b1111, ovfl_cnt=2.
- a=16'h8000, b=16'h1000, sub=1:
  - sat_en=1 -> sum=16'h8000, ovfl=4'b1000.
  - sat_en=0 -> sum=16'h7000, ovfl=4'b1000.
- Backpressure: out_ready=0 while offering 3 back-to-back beats -> exactly 2 accepted, in_ready=0 from the third cycle, sum held stable. Raise out_ready -> beats emerge in order, one per cycle, then the third is accepted.
- clr_err pulses:
  - With no handshake -> err=0, ovfl_cnt=0.
  - Same cycle as an overflowing output handshake -> err=1, ovfl_cnt=1.
  - With CNT_W=2, 5 overflowing beats -> ovfl_cnt sticks at 3.
- Assert rst asynchronously with 2 beats in flight -> out_valid, sum, ovfl, err, ovfl_cnt go to 0 immediately, no stale beat after release, in_ready=1 the first cycle after release.

Source files
------------

// File: rtl/psa_pipe_if.sv
// Operand/result bus for the partitioned signed adder: an input beat channel
// and a result beat channel, each with its own valid/ready pair.
interface psa_pipe_if #(
  parameter int LANE_W = 4,
  parameter int LANES  = 4
);
  localparam int W = LANE_W * LANES;

  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      a;
  logic [W-1:0]      b;
  logic              sub;
  logic              sat_en;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      sum;
  logic [LANES-1:0]  ovfl;

  // master: produces operand beats and consumes result beats
  modport master (
    output in_valid, a, b, sub, sat_en, out_ready,
    input  in_ready, out_valid, sum, ovfl
  );

  // slave: the adder pipeline itself
  modport slave (
    input  in_valid, a, b, sub, sat_en, out_ready,
    output in_ready, out_valid, sum, ovfl
  );
endinterface

// File: rtl/psa_pipe.sv
// Two-stage pipelined partitioned signed add/subtract with per-beat saturate
// or wrap, sticky overflow flag and saturating overflow event counter.
module psa_pipe #(
  parameter int LANE_W = 4,
  parameter int LANES  = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  psa_pipe_if.slave        bus,
  input  logic             clr_err,
  output logic             err,
  output logic [CNT_W-1:0] ovfl_cnt
);
  localparam int W = LANE_W * LANES;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s1_valid;
  logic             s1_sat;
  logic [W-1:0]     s1_raw;
  logic [LANES-1:0] s1_ov;
  logic             s2_valid;
  logic [W-1:0]     s2_sum;
  logic [LANES-1:0] s2_ovfl;

  logic [W-1:0]     raw_c;
  logic [LANES-1:0] ov_c;
  logic [W-1:0]     sat_c;
  logic             s1_adv;
  logic             s2_adv;
  logic             out_fire;
  logic             ovfl_event;

  // Each lane has its own adder; no carry crosses a lane boundary.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0] la;
    logic [LANE_W-1:0] lb;
    logic [LANE_W-1:0] lbx;
    logic [LANE_W-1:0] lr;
    logic [LANE_W-1:0] rr;

    assign la  = bus.a[i*LANE_W +: LANE_W];
    assign lb  = bus.b[i*LANE_W +: LANE_W];
    assign lbx = bus.sub ? ~lb : lb;
    assign lr  = la + lbx + {{(LANE_W-1){1'b0}}, bus.sub};
    assign raw_c[i*LANE_W +: LANE_W] = lr;
    // add needs equal operand signs, sub needs differing ones, then a sign flip
    assign ov_c[i] = ((la[LANE_W-1] ^ lb[LANE_W-1]) == bus.sub) &&
                     (lr[LANE_W-1] != la[LANE_W-1]);

    assign rr = s1_raw[i*LANE_W +: LANE_W];
    assign sat_c[i*LANE_W +: LANE_W] =
      (s1_ov[i] && s1_sat) ?
        (rr[LANE_W-1] ? {1'b0, {(LANE_W-1){1'b1}}} : {1'b1, {(LANE_W-1){1'b0}}}) :
        rr;
  end

  // Handshake: a beat moves on a rising edge where its valid and ready are
  // both 1. Each stage advances when empty or when its successor advances, so
  // in_ready depends on out_ready and stage occupancy, never on in_valid.
  assign s2_adv     = !s2_valid || bus.out_ready;
  assign s1_adv     = !s1_valid || s2_adv;
  assign out_fire   = s2_valid && bus.out_ready;
  assign ovfl_event = out_fire && (|s2_ovfl);

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.sum       = s2_sum;
  assign bus.ovfl      = s2_ovfl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sat   <= 1'b0;
      s1_raw   <= '0;
      s1_ov    <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sat <= bus.sat_en;
        s1_raw <= raw_c;
        s1_ov  <= ov_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_ovfl  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sum  <= sat_c;
        s2_ovfl <= s1_ov;
      end
    end
  end

  // An overflowing delivery beats a coincident clear and restarts the count at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err      <= 1'b0;
      ovfl_cnt <= '0;
    end else if (ovfl_event) begin
      err <= 1'b1;
      if (clr_err)
        ovfl_cnt <= CNT_ONE;
      else if (ovfl_cnt != CNT_MAX)
        ovfl_cnt <= ovfl_cnt + CNT_ONE;
    end else if (clr_err) begin
      err      <= 1'b0;
      ovfl_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_psa_pipe.sv
// Bench for psa_pipe: directed plan cases plus randomized traffic checked
// against an integer-arithmetic lane model and an expected-beat queue.
module tb_psa_pipe;
  localparam int LW = 4;
  localparam int LN = 4;
  localparam int W  = LW * LN;

  logic       clk;
  logic       rst;
  logic       clr_err;
  logic       err, err2;
  logic [7:0] ovfl_cnt;
  logic [1:0] ovfl_cnt2;

  psa_pipe_if #(.LANE_W(LW), .LANES(LN)) ifc ();
  psa_pipe_if #(.LANE_W(LW), .LANES(LN)) ifc2 ();

  assign ifc2.in_valid  = ifc.in_valid;
  assign ifc2.a         = ifc.a;
  assign ifc2.b         = ifc.b;
  assign ifc2.sub       = ifc.sub;
  assign ifc2.sat_en    = ifc.sat_en;
  assign ifc2.out_ready = ifc.out_ready;

  psa_pipe #(.LANE_W(LW), .LANES(LN), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(ifc), .clr_err(clr_err),
    .err(err), .ovfl_cnt(ovfl_cnt)
  );

  psa_pipe #(.LANE_W(LW), .LANES(LN), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(ifc2), .clr_err(clr_err),
    .err(err2), .ovfl_cnt(ovfl_cnt2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [W+LN-1:0] exp_q[$];
  int              acc_q[$];
  int              checks = 0;
  int              passes = 0;
  int              cyc = 0;
  int              lat_last = 0;
  logic [W-1:0]    lsum;
  logic [LN-1:0]   lovfl;
  bit              m_err = 0;
  int              m_cnt = 0;
  int              m_cnt2 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%0h required=%0h", tag, obs, expv);
  endtask

  // Reference: each lane as a signed integer, exact result then clamp or wrap.
  function automatic logic [W+LN-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input bit s, input bit sat);
    logic [W-1:0]  rs;
    logic [LN-1:0] ro;
    int xa, xb, r, mx, mn;
    mx = (1 << (LW-1)) - 1;
    mn = -(1 << (LW-1));
    rs = '0;
    ro = '0;
    for (int i = 0; i < LN; i++) begin
      xa = $signed(a[i*LW +: LW]);
      xb = $signed(b[i*LW +: LW]);
      r  = s ? xa - xb : xa + xb;
      ro[i] = (r > mx) || (r < mn);
      if (ro[i] && sat) r = (r > mx) ? mx : mn;
      rs[i*LW +: LW] = r[LW-1:0];
    end
    return {ro, rs};
  endfunction

  // One clock: evaluate both handshakes mid-cycle, then check sticky status.
  task automatic cycle(output bit acc);
    logic [W+LN-1:0] e;
    bit fire, ev;
    @(negedge clk);
    chk("in_ready", ifc.in_ready, (exp_q.size() < 2) || ifc.out_ready);
    if (exp_q.size() == 0) chk("idle_out_valid", ifc.out_valid, 0);
    fire = ifc.out_valid && ifc.out_ready;
    ev = 0;
    if (fire && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sum", ifc.sum, e[W-1:0]);
      chk("ovfl", ifc.ovfl, e[W+LN-1:W]);
      lsum = ifc.sum;
      lovfl = ifc.ovfl;
      lat_last = cyc - acc_q.pop_front();
      ev = |e[W+LN-1:W];
    end
    if (ev) begin
      m_err  = 1;
      m_cnt  = clr_err ? 1 : (m_cnt == 255 ? 255 : m_cnt + 1);
      m_cnt2 = clr_err ? 1 : (m_cnt2 == 3 ? 3 : m_cnt2 + 1);
    end else if (clr_err) begin
      m_err = 0; m_cnt = 0; m_cnt2 = 0;
    end
    acc = ifc.in_valid && ifc.in_ready;
    if (acc) begin
      exp_q.push_back(model(ifc.a, ifc.b, ifc.sub, ifc.sat_en));
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("err", err, m_err);
    chk("ovfl_cnt", ovfl_cnt, m_cnt);
    chk("ovfl_cnt_w2", ovfl_cnt2, m_cnt2);
  endtask

  // driver: hold one beat until accepted
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input bit sat);
    bit acc;
    int n;
    n = 0;
    ifc.in_valid = 1; ifc.a = a; ifc.b = b; ifc.sub = s; ifc.sat_en = sat;
    do begin
      cycle(acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 0, 1);
    ifc.in_valid = 0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      cycle(acc);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    bit acc;
    logic [W-1:0] hold_sum;
    rst = 1; clr_err = 0;
    ifc.in_valid = 0; ifc.a = '0; ifc.b = '0; ifc.sub = 0; ifc.sat_en = 0;
    ifc.out_ready = 1;
    #1;
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_sum", ifc.sum, 0);
    chk("rst_ovfl", ifc.ovfl, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", ovfl_cnt, 0);
    repeat (2) @(posedge clk);
    #2 rst = 0;
    @(posedge clk); #1;

    // basic add, latency 2
    send(16'h1234, 16'h1111, 0, 1);
    drain();
    chk("t1_sum", lsum, 16'h2345);
    chk("t1_ovfl", lovfl, 4'b0000);
    chk("t1_latency", lat_last, 2);
    chk("t1_err", err, 0);
    chk("t1_cnt", ovfl_cnt, 0);

    // positive and negative saturation
    send(16'h7777, 16'h1111, 0, 1);
    drain();
    chk("t2_sum", lsum, 16'h7777);
    chk("t2_ovfl", lovfl, 4'b1111);
    chk("t2_err", err, 1);
    chk("t2_cnt", ovfl_cnt, 1);
    send(16'h8888, 16'h8888, 0, 1);
    drain();
    chk("t3_sum", lsum, 16'h8888);
    chk("t3_ovfl", lovfl, 4'b1111);
    chk("t3_cnt", ovfl_cnt, 2);

    // subtract, saturate vs wrap
    send(16'h8000, 16'h1000, 1, 1);
    drain();
    chk("t4_sum", lsum, 16'h8000);
    chk("t4_ovfl", lovfl, 4'b1000);
    send(16'h8000, 16'h1000, 1, 0);
    drain();
    chk("t5_sum", lsum, 16'h7000);
    chk("t5_ovfl", lovfl, 4'b1000);

    // backpressure: two beats fill the pipe, the third waits
    ifc.out_ready = 0;
    ifc.in_valid = 1; ifc.a = 16'h1357; ifc.b = 16'h2222; ifc.sub = 0; ifc.sat_en = 1;
    cycle(acc); chk("bp_acc0", acc, 1);
    ifc.a = 16'h4321; ifc.b = 16'h1234; ifc.sub = 1;
    cycle(acc); chk("bp_acc1", acc, 1);
    ifc.a = 16'h0f0f; ifc.b = 16'h0101; ifc.sub = 0; ifc.sat_en = 0;
    cycle(acc); chk("bp_acc2_blocked", acc, 0);
    hold_sum = ifc.sum;
    cycle(acc); chk("bp_still_blocked", acc, 0);
    chk("bp_sum_stable", ifc.sum, hold_sum);
    chk("bp_out_valid", ifc.out_valid, 1);
    ifc.out_ready = 1;
    cycle(acc); chk("bp_acc2_now", acc, 1);
    ifc.in_valid = 0;
    drain();

    // clear with no handshake
    clr_err = 1; cycle(acc); clr_err = 0;
    chk("clr_idle_err", err, 0);
    chk("clr_idle_cnt", ovfl_cnt, 0);

    // clear coinciding with an overflowing delivery
    send(16'h7777, 16'h1111, 0, 1);
    send(16'h7777, 16'h1111, 0, 1);
    drain();
    ifc.out_ready = 0;
    send(16'h7000, 16'h7000, 0, 1);
    repeat (3) cycle(acc);
    clr_err = 1; ifc.out_ready = 1;
    cycle(acc);
    clr_err = 0;
    chk("clr_coinc_err", err, 1);
    chk("clr_coinc_cnt", ovfl_cnt, 1);

    // counter saturation on the narrow-counter instance
    clr_err = 1; cycle(acc); clr_err = 0;
    repeat (5) send(16'h7777, 16'h1111, 0, 1);
    drain();
    chk("sat_cnt_w2", ovfl_cnt2, 3);
    chk("sat_cnt_w8", ovfl_cnt, 5);
    chk("sat_err_w2", err2, 1);

    // randomized traffic
    acc = 0;
    for (int k = 0; k < 400; k++) begin
      if (!ifc.in_valid || acc) begin
        ifc.in_valid = ($urandom_range(0, 3) != 0);
        ifc.a = W'($urandom);
        ifc.b = W'($urandom);
        ifc.sub = 1'($urandom_range(0, 1));
        ifc.sat_en = 1'($urandom_range(0, 1));
      end
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      clr_err = ($urandom_range(0, 15) == 0);
      cycle(acc);
    end
    clr_err = 0; ifc.in_valid = 0; ifc.out_ready = 1;
    drain();

    // asynchronous reset with two beats in flight
    ifc.out_ready = 0;
    send(16'h7777, 16'h1111, 0, 1);
    send(16'h1234, 16'h1111, 0, 1);
    #3 rst = 1;
    #1;
    chk("arst_out_valid", ifc.out_valid, 0);
    chk("arst_sum", ifc.sum, 0);
    chk("arst_ovfl", ifc.ovfl, 0);
    chk("arst_err", err, 0);
    chk("arst_cnt", ovfl_cnt, 0);
    exp_q.delete(); acc_q.delete();
    m_err = 0; m_cnt = 0; m_cnt2 = 0;
    ifc.out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    repeat (5) cycle(acc);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $fatal(1, "FAIL global_timeout observed=running required=finished");
  end
endmodule
